// File: rtl/lsu_access_ctrl.sv
`default_nettype none
// ============================================================================
// lsu_access_ctrl : byte-enabled load/store initiator, splits unaligned
//                   accesses into two word beats and extends load data.
// Revision 1.0
// ============================================================================
module lsu_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic crosses_word(input logic [1:0] size, input logic [1:0] off);
    logic [2:0] nbytes;
    case (size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    return (({1'b0, off} + nbytes) > 3'd4);
  endfunction

  // Shift the two captured words down to the access offset, then extend.
  function automatic logic [31:0] load_extend(input logic [31:0] lo, input logic [31:0] hi,
                                              input logic [1:0] size, input logic [1:0] off,
                                              input logic sgn);
    logic [31:0] raw;
    raw = 32'({hi, lo} >> {off, 3'b000});
    case (size)
      2'b00:   return {{24{sgn & raw[7]}}, raw[7:0]};
      2'b01:   return {{16{sgn & raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  state_e              state_q, state_d;
  logic                store_q, store_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [1:0]          off_q, off_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         lo_q, lo_d;
  logic [31:0]         hi_q, hi_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;
  logic                mem_we_q, mem_we_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
  logic [31:0]         mem_wd_q, mem_wd_d;

  logic [1:0]  acc_off;
  logic [3:0]  acc_be;
  logic [31:0] acc_wd;
  logic [3:0]  hi_be;
  logic [31:0] hi_wd;
  logic        cur_split;

  // First-beat lanes come from the incoming request, second-beat lanes are the
  // bits that spill past the top of the word when shifting the captured request.
  assign acc_off   = req_addr[1:0];
  assign acc_be    = size_mask(req_size) << acc_off;
  assign acc_wd    = req_wdata << {acc_off, 3'b000};
  assign hi_be     = 4'(({4'b0000, size_mask(size_q)} << off_q) >> 4);
  assign hi_wd     = 32'(({32'h0, wdata_q} << {off_q, 3'b000}) >> 32);
  assign cur_split = crosses_word(size_q, off_q);

  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    size_d       = size_q;
    signed_d     = signed_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_a_d      = mem_a_q;
    mem_wd_d     = mem_wd_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          store_d     = req_store;
          size_d      = req_size;
          signed_d    = req_signed;
          off_d       = acc_off;
          wdata_d     = req_wdata;
          lo_d        = '0;
          hi_d        = '0;
          req_ready_d = 1'b0;
          mem_we_d    = req_store;
          mem_be_d    = acc_be;
          mem_a_d     = {req_addr[ADDR_W-1:2], 2'b00};
          mem_wd_d    = acc_wd;
          state_d     = S_BEAT0;
        end
      end
      S_BEAT0: begin
        if (!store_q) lo_d = mem_rd;
        if (cur_split) begin
          mem_a_d  = mem_a_q + ADDR_W'(4);
          mem_be_d = hi_be;
          mem_wd_d = hi_wd;
          state_d  = S_BEAT1;
        end else begin
          hi_d         = '0;
          mem_we_d     = 1'b0;
          mem_be_d     = 4'b0000;
          resp_valid_d = 1'b1;
          resp_rdata_d = store_q ? 32'h0 : load_extend(lo_d, hi_d, size_q, off_q, signed_q);
          state_d      = S_RESP;
        end
      end
      S_BEAT1: begin
        if (!store_q) hi_d = mem_rd;
        mem_we_d     = 1'b0;
        mem_be_d     = 4'b0000;
        resp_valid_d = 1'b1;
        resp_rdata_d = store_q ? 32'h0 : load_extend(lo_q, hi_d, size_q, off_q, signed_q);
        state_d      = S_RESP;
      end
      S_RESP: begin
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0;
        req_ready_d  = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      store_q      <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= 32'h0;
      lo_q         <= 32'h0;
      hi_q         <= 32'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'b0000;
      mem_a_q      <= '0;
      mem_wd_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_a_q      <= mem_a_d;
      mem_wd_q     <= mem_wd_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_a      = mem_a_q;
  assign mem_wd     = mem_wd_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_access_ctrl.sv
`default_nettype none
// ============================================================================
// tb_lsu_access_ctrl : directed self-checking bench for lsu_access_ctrl.
// Revision 1.0
// ============================================================================
module tb_lsu_access_ctrl;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  lsu_access_ctrl #(.ADDR_W(32)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1 KiB byte-enabled memory, aliased over the address space
  logic [31:0] mem_model [0:255] = '{default: 32'h0};
  assign mem_rd = mem_model[mem_a[9:2]];
  always @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) mem_model[mem_a[9:2]][8*i +: 8] <= mem_wd[8*i +: 8];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [3:0]  b_be [2];
  logic [31:0] b_a  [2];
  logic [31:0] b_wd [2];
  logic        b_we [2];
  int          nbeats;
  int          lat;
  logic [31:0] got_rdata;

  // Issue one request from a negedge and record beats and response latency.
  task automatic xact(input logic st, input logic [1:0] sz, input logic sg,
                      input logic [31:0] ad, input logic [31:0] wd);
    int guard;
    guard = 0;
    while (!req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    req_valid  = 1'b1;
    req_store  = st;
    req_size   = sz;
    req_signed = sg;
    req_addr   = ad;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    nbeats    = 0;
    lat       = -1;
    got_rdata = 32'h0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (mem_be != 4'b0000 && nbeats < 2) begin
        b_be[nbeats] = mem_be;
        b_a[nbeats]  = mem_a;
        b_wd[nbeats] = mem_wd;
        b_we[nbeats] = mem_we;
        nbeats++;
      end
      if (resp_valid) begin
        lat       = k;
        got_rdata = resp_rdata;
        break;
      end
    end
  endtask

  initial begin
    int n_ready;
    int n_resp;
    logic bad;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_val("rst_ready", 32'(req_ready), 32'd1);
    chk_val("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk_val("rst_rdata", resp_rdata, 32'h0);
    chk_val("rst_we", 32'(mem_we), 32'd0);
    chk_val("rst_be", 32'(mem_be), 32'd0);
    chk_val("rst_a", mem_a, 32'h0);
    chk_val("rst_wd", mem_wd, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // aligned word store / load
    xact(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
    chk_val("sw_beats", nbeats, 1);
    chk_val("sw_be", 32'(b_be[0]), 32'hF);
    chk_val("sw_a", b_a[0], 32'h100);
    chk_val("sw_we", 32'(b_we[0]), 32'd1);
    chk_val("sw_wd", b_wd[0], 32'hDEADBEEF);
    chk_val("sw_lat", lat, 2);
    chk_val("sw_rdata", got_rdata, 32'h0);
    xact(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    chk_val("lw_we", 32'(b_we[0]), 32'd0);
    chk_val("lw_lat", lat, 2);
    chk_val("lw_rdata", got_rdata, 32'hDEADBEEF);

    // byte lanes
    xact(1'b1, 2'b00, 1'b0, 32'h103, 32'h0000005A);
    chk_val("sb_be", 32'(b_be[0]), 32'h8);
    chk_val("sb_wd", b_wd[0] & 32'hFF000000, 32'h5A000000);
    chk_val("sb_mem", mem_model[8'h40], 32'h5AADBEEF);
    xact(1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
    chk_val("lbs_5a", got_rdata, 32'h0000005A);
    xact(1'b1, 2'b00, 1'b0, 32'h103, 32'h00000080);
    xact(1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
    chk_val("lbs_80", got_rdata, 32'hFFFFFF80);
    xact(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
    chk_val("lbu_80", got_rdata, 32'h00000080);

    // halfwords
    xact(1'b1, 2'b01, 1'b0, 32'h102, 32'h00008001);
    chk_val("sh_be", 32'(b_be[0]), 32'hC);
    chk_val("sh_mem", mem_model[8'h40], 32'h8001BEEF);
    xact(1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
    chk_val("lhs", got_rdata, 32'hFFFF8001);
    chk_val("lhs_lat", lat, 2);
    xact(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
    chk_val("lhu", got_rdata, 32'h00008001);
    xact(1'b1, 2'b01, 1'b0, 32'h103, 32'h0000BEEF);
    chk_val("shs_beats", nbeats, 2);
    chk_val("shs_be0", 32'(b_be[0]), 32'h8);
    chk_val("shs_a0", b_a[0], 32'h100);
    chk_val("shs_wd0", b_wd[0] & 32'hFF000000, 32'hEF000000);
    chk_val("shs_be1", 32'(b_be[1]), 32'h1);
    chk_val("shs_a1", b_a[1], 32'h104);
    chk_val("shs_wd1", b_wd[1] & 32'h000000FF, 32'h000000BE);
    chk_val("shs_lat", lat, 3);
    xact(1'b0, 2'b01, 1'b0, 32'h103, 32'h0);
    chk_val("lhs_split", got_rdata, 32'h0000BEEF);
    chk_val("lhs_split_lat", lat, 3);

    // split word load
    xact(1'b1, 2'b10, 1'b0, 32'h100, 32'h44332211);
    xact(1'b1, 2'b10, 1'b0, 32'h104, 32'h88776655);
    xact(1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
    chk_val("lws_rdata", got_rdata, 32'h55443322);
    chk_val("lws_lat", lat, 3);
    chk_val("lws_be0", 32'(b_be[0]), 32'hE);
    chk_val("lws_be1", 32'(b_be[1]), 32'h1);
    chk_val("lws_a1", b_a[1], 32'h104);

    // split word store
    xact(1'b1, 2'b10, 1'b0, 32'h1FE, 32'hAABBCCDD);
    chk_val("sws_be0", 32'(b_be[0]), 32'hC);
    chk_val("sws_a0", b_a[0], 32'h1FC);
    chk_val("sws_wd0", b_wd[0] & 32'hFFFF0000, 32'hCCDD0000);
    chk_val("sws_be1", 32'(b_be[1]), 32'h3);
    chk_val("sws_a1", b_a[1], 32'h200);
    chk_val("sws_wd1", b_wd[1] & 32'h0000FFFF, 32'h0000AABB);
    xact(1'b0, 2'b10, 1'b0, 32'h1FE, 32'h0);
    chk_val("sws_readback", got_rdata, 32'hAABBCCDD);

    // address wrap on the second beat
    xact(1'b1, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h12345678);
    xact(1'b1, 2'b10, 1'b0, 32'h00000000, 32'h9ABCDEF0);
    xact(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0);
    chk_val("wrap_a0", b_a[0], 32'hFFFFFFFC);
    chk_val("wrap_a1", b_a[1], 32'h00000000);
    chk_val("wrap_rdata", got_rdata, 32'hDEF01234);

    // reset during the first beat of a split store
    @(negedge clk);
    req_valid = 1'b1;
    req_store = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h201;
    req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk_val("abort_b0_we", 32'(mem_we), 32'd1);
    chk_val("abort_b0_be", 32'(mem_be), 32'hE);
    reset_n = 1'b0;
    @(negedge clk);
    chk_val("abort_we", 32'(mem_we), 32'd0);
    chk_val("abort_be", 32'(mem_be), 32'd0);
    chk_val("abort_resp", 32'(resp_valid), 32'd0);
    chk_val("abort_ready", 32'(req_ready), 32'd1);
    reset_n = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || mem_we) bad = 1'b1;
    end
    chk_val("abort_quiet", 32'(bad), 32'd0);
    chk_val("abort_mem0", mem_model[8'h80], 32'hFEF00DBB);
    chk_val("abort_mem1", mem_model[8'h81], 32'h00000000);

    // requests held back-to-back: one accept per three cycles
    n_ready = 0;
    n_resp  = 0;
    req_valid  = 1'b1;
    req_store  = 1'b0;
    req_size   = 2'b10;
    req_signed = 1'b0;
    req_addr   = 32'h100;
    for (int k = 0; k < 9; k++) begin
      if (req_ready) n_ready++;
      if (resp_valid) begin
        n_resp++;
        chk_val("b2b_rdata", resp_rdata, 32'h44332211);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk_val("b2b_ready_cycles", n_ready, 3);
    chk_val("b2b_resp_count", n_resp, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/lsu_access_ctrl.md
# lsu_access_ctrl

Load/store access controller for the SimpleARM datapath: the initiator side of the byte-enabled data memory port. It accepts one load or store request at a time from the core and converts byte/halfword/word accesses at any byte offset into one or two word-aligned memory beats with byte enables. For loads it merges and shifts the returned lanes, then zero- or sign-extends them. Sits between the execute/memory stage and the data memory (combinational read, write on rising clk when `mem_we`).

## Interface
- `ADDR_W`, 32, address width; bits [1:0] select the byte offset.

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept (high only in IDLE)
- `req_store`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
- `req_signed`  in  1  load sign-extension enable (ignored for word and stores)
- `req_addr`  in  ADDR_W  byte address, any alignment
- `req_wdata`  in  32  store data, right-justified
- `resp_valid`  out  1  one-cycle completion pulse (loads and stores)
- `resp_rdata`  out  32  extended load data; 0 for stores
- `mem_we`  out  1  memory write strobe
- `mem_be`  out  4  byte-lane enables, bit i = lane [8i+7:8i]
- `mem_a`  out  ADDR_W  word-aligned address (bits [1:0] = 0)
- `mem_wd`  out  32  lane-positioned write data
- `mem_rd`  in  32  combinational memory read data

## Operation
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE: `req_ready`=1. On `req_valid`: register store/size/signed/addr/wdata → BEAT0.
- Definitions: o = addr[1:0]; n = 1/2/4 bytes; mask = 0001/0011/1111; split = (o + n > 4).
- BEAT0: `mem_a` = {addr[ADDR_W-1:2],2'b00}; `mem_be` = (mask << o)[3:0]; `mem_wd` = (wdata << 8o)[31:0]; `mem_we` = store. Loads capture `mem_rd` into lo register. → BEAT1 if split, else RESP.
- BEAT1: `mem_a` = BEAT0 address + 4, wrapping modulo 2^ADDR_W; `mem_be` = mask >> (4−o); `mem_wd` = wdata >> 8(4−o); `mem_we` = store. Loads capture `mem_rd` into hi register (hi = 0 if not split). → RESP.
- RESP: `resp_valid`=1; for loads, `resp_rdata` = low n bytes of ({hi,lo} >> 8o), sign-extended from bit 8n−1 if `req_signed` and n<4, else zero-extended. Stores: `resp_rdata`=0. → IDLE.
- Bytes never split; halfword splits only at o=3; word splits at o≠0.
- Lanes not enabled by `mem_be` are never written; `mem_wd` in disabled lanes is don't-care.
- Outside BEAT0/BEAT1: `mem_we`=0, `mem_be`=0.

## Timing
- Reset (`reset_n`=0 at a rising edge): state IDLE; `req_ready`=1 after the edge; `resp_valid`=0, `resp_rdata`=0, `mem_we`=0, `mem_be`=0, `mem_a`=0, `mem_wd`=0, lo/hi=0.
- Reset mid-transaction aborts it: no further `mem_we`, no `resp_valid`. A beat already written stays written.
- Accept at edge T → BEAT0 in cycle T+1 → `resp_valid` in cycle T+2 (aligned) or T+3 (split).
- Throughput: one request per 3 (aligned) or 4 (split) cycles; `req_ready` low from BEAT0 through RESP. A request in RESP is not accepted until IDLE.
- `resp_valid` is high exactly one cycle and is not backpressured.
- All memory-side outputs are decoded from registered state only; no combinational path from `req_*` to `mem_*`.
- `mem_rd` is sampled at the end of the beat cycle in which `mem_a` is driven.

## Test plan
- Aligned word store then load: store 0xDEADBEEF @0x100 → one beat, `mem_be`=1111, `mem_a`=0x100; load @0x100 → `resp_rdata`=0xDEADBEEF at T+2.
- Byte lanes: STRB 0x5A @0x103 → `mem_be`=1000, `mem_wd`[31:24]=0x5A, other bytes of word unchanged. LDRB signed @0x103 → 0x0000005A; after STRB 0x80, signed → 0xFFFFFF80, unsigned → 0x00000080.
- Halfword: LDRH signed @0x102, word=0x8001xxxx → 0xFFFF8001. STRH 0xBEEF @0x103 → BEAT0 be=1000 @0x100, BEAT1 be=0001 @0x104; re-read returns 0xBEEF at T+3.
- Split word load @0x101, memory words 0x44332211 @0x100 and 0x88776655 @0x104 → 0x55443322, `resp_valid` at T+3; split store @0x1FE of 0xAABBCCDD → be 1100 then 0011.
- Wrap: word load @0xFFFFFFFE → BEAT1 `mem_a`=0x00000000.
- Reset during BEAT0 of split store → BEAT1 never issued, `resp_valid` stays 0, `req_ready`=1 next cycle; back-to-back `req_valid` held high → accepted only in IDLE.
